divider_8_4_seq: RTL and testbench

- Sequential unsigned restoring divider: the inverse operation of the team's 4x4 array multiplier.
- Takes an 8-bit product-sized dividend and a 4-bit divisor, and returns an 8-bit quotient and a 4-bit remainder.
- Produces one quotient bit per clock, with a start/busy/done handshake.
- Sits beside the multiplier in the arithmetic datapath and checks products through round trips (a*b/b == a).

---
 rtl/divider_pkg.sv | 12 +
 rtl/div_step.sv | 21 ++
 rtl/divider_8_4_seq.sv | 114 +++++++++++
 tb/tb_divider_8_4_seq.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/divider_pkg.sv
// Shared constants for the sequential restoring divider: FSM encoding,
// default operand widths and the divide-by-zero quotient.
package divider_pkg;
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam int DEF_DIVIDEND_W = 8;
   localparam int DEF_DIVISOR_W  = 4;

   localparam logic [DEF_DIVIDEND_W-1:0] QUOT_DIV0 = '1;
endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module div_step #(
   parameter int DIVISOR_W = 4
) (
   input  logic [DIVISOR_W:0]   prem_i,
   input  logic                 bit_i,
   input  logic [DIVISOR_W-1:0] divisor_i,
   output logic [DIVISOR_W:0]   prem_o,
   output logic                 qbit_o
);
   logic [DIVISOR_W:0] t;
   logic [DIVISOR_W:0] dv;

   assign t  = {prem_i[DIVISOR_W-1:0], bit_i};
   assign dv = {1'b0, divisor_i};

   // A set top bit means the shifted value overflowed t, so it always fits.
   assign qbit_o = prem_i[DIVISOR_W] | (t >= dv);
   assign prem_o = qbit_o ? (t - dv) : t;
endmodule

// File: rtl/divider_8_4_seq.sv
// Sequential unsigned restoring divider, one quotient bit per clock, with a
// start/busy/done handshake and a divide-by-zero flag.
module divider_8_4_seq
   import divider_pkg::*;
#(
   parameter int DIVIDEND_W = DEF_DIVIDEND_W,
   parameter int DIVISOR_W  = DEF_DIVISOR_W,
   parameter int CNT_W      = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [DIVIDEND_W-1:0] dividend,
   input  logic [DIVISOR_W-1:0]  divisor,
   output logic                  busy,
   output logic                  done,
   output logic [DIVIDEND_W-1:0] quotient,
   output logic [DIVISOR_W-1:0]  remainder,
   output logic                  div_by_zero
);
   logic [1:0]            state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [DIVISOR_W:0]    prem_q, prem_d, prem_n;
   logic [DIVIDEND_W-1:0] qreg_q, qreg_d;
   logic [DIVISOR_W-1:0]  div_q, div_d;
   logic [DIVIDEND_W-1:0] quot_q, quot_d;
   logic [DIVISOR_W-1:0]  rem_q, rem_d;
   logic                  dbz_q, dbz_d;
   logic                  qbit;

   div_step #(.DIVISOR_W(DIVISOR_W)) u_step (
      .prem_i    (prem_q),
      .bit_i     (qreg_q[DIVIDEND_W-1]),
      .divisor_i (div_q),
      .prem_o    (prem_n),
      .qbit_o    (qbit)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = (divisor == '0) ? S_DONE : S_RUN;
         S_RUN:   if (cnt_q == CNT_W'(1)) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy = (state_q == S_RUN);
      done = (state_q == S_DONE);
   end

   // Datapath: operands are captured only on the accepting edge in IDLE.
   always_comb begin
      cnt_d  = cnt_q;
      prem_d = prem_q;
      qreg_d = qreg_q;
      div_d  = div_q;
      quot_d = quot_q;
      rem_d  = rem_q;
      dbz_d  = dbz_q;
      if (state_q == S_IDLE && start) begin
         if (divisor == '0) begin
            quot_d = QUOT_DIV0;
            rem_d  = '0;
            dbz_d  = 1'b1;
         end else begin
            div_d  = divisor;
            prem_d = '0;
            qreg_d = dividend;
            cnt_d  = CNT_W'(DIVIDEND_W);
         end
      end else if (state_q == S_RUN) begin
         prem_d = prem_n;
         qreg_d = {qreg_q[DIVIDEND_W-2:0], qbit};
         cnt_d  = cnt_q - CNT_W'(1);
         if (cnt_q == CNT_W'(1)) begin
            quot_d = {qreg_q[DIVIDEND_W-2:0], qbit};
            rem_d  = prem_n[DIVISOR_W-1:0];
            dbz_d  = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= '0;
         prem_q <= '0;
         qreg_q <= '0;
         div_q  <= '0;
         quot_q <= '0;
         rem_q  <= '0;
         dbz_q  <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         prem_q <= prem_d;
         qreg_q <= qreg_d;
         div_q  <= div_d;
         quot_q <= quot_d;
         rem_q  <= rem_d;
         dbz_q  <= dbz_d;
      end
   end

   assign quotient    = quot_q;
   assign remainder   = rem_q;
   assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_divider_8_4_seq.sv
// Directed bench for divider_8_4_seq: latency, results, divide-by-zero,
// busy protection and reset abort.
module tb_divider_8_4_seq;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [7:0] dividend = '0;
   logic [3:0] divisor = '0;
   logic       busy, done, div_by_zero;
   logic [7:0] quotient;
   logic [3:0] remainder;

   int n_checks = 0;
   int n_fail   = 0;

   divider_8_4_seq dut (
      .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
      .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
      .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   // Start a division and watch 20 cycles. lat = cycles from the start edge
   // to the cycle in which done is seen (-1 if never), bcnt = busy cycles.
   task automatic run_div(input logic [7:0] a, input logic [3:0] b,
                          output int lat, output int bcnt, output int ndone);
      @(negedge clk);
      dividend = a; divisor = b; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = -1; bcnt = 0; ndone = 0;
      for (int k = 0; k < 20; k++) begin
         if (k > 0) @(negedge clk);
         if (busy) bcnt++;
         if (done) begin
            ndone++;
            if (lat < 0) lat = k + 1;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++;
      if ({busy, done, quotient, remainder, div_by_zero} !== 15'd0) begin
         n_fail++;
         $display("FAIL reset_idle: got busy=%0b done=%0b q=%0d r=%0d dbz=%0b, want all 0",
                  busy, done, quotient, remainder, div_by_zero);
      end
   endtask

   task automatic test_round_trip();
      logic [7:0] va [4] = '{8'd225, 8'd104, 8'd195, 8'd108};
      logic [3:0] vb [4] = '{4'd15, 4'd8, 4'd13, 4'd9};
      logic [7:0] vq [4] = '{8'd15, 8'd13, 8'd15, 8'd12};
      int lat, bcnt, nd;
      for (int i = 0; i < 4; i++) begin
         run_div(va[i], vb[i], lat, bcnt, nd);
         n_checks++;
         if (quotient !== vq[i] || remainder !== 4'd0 || div_by_zero !== 1'b0) begin
            n_fail++;
            $display("FAIL round_trip %0d/%0d: got q=%0d r=%0d dbz=%0b, want q=%0d r=0 dbz=0",
                     va[i], vb[i], quotient, remainder, div_by_zero, vq[i]);
         end
         n_checks++;
         if (lat !== 9 || bcnt !== 8 || nd !== 1) begin
            n_fail++;
            $display("FAIL round_trip_timing %0d/%0d: got lat=%0d busy=%0d dones=%0d, want 9/8/1",
                     va[i], vb[i], lat, bcnt, nd);
         end
      end
   endtask

   task automatic test_edges();
      logic [7:0] va [4] = '{8'd255, 8'd0, 8'd7, 8'd255};
      logic [3:0] vb [4] = '{4'd7, 4'd5, 4'd15, 4'd1};
      logic [7:0] vq [4] = '{8'd36, 8'd0, 8'd0, 8'd255};
      logic [3:0] vr [4] = '{4'd3, 4'd0, 4'd7, 4'd0};
      int lat, bcnt, nd;
      for (int i = 0; i < 4; i++) begin
         run_div(va[i], vb[i], lat, bcnt, nd);
         n_checks++;
         if (quotient !== vq[i] || remainder !== vr[i] || lat !== 9 || nd !== 1) begin
            n_fail++;
            $display("FAIL edge %0d/%0d: got q=%0d r=%0d lat=%0d dones=%0d, want q=%0d r=%0d lat=9 dones=1",
                     va[i], vb[i], quotient, remainder, lat, nd, vq[i], vr[i]);
         end
      end
   endtask

   task automatic test_div_zero();
      int lat, bcnt, nd;
      run_div(8'd200, 4'd0, lat, bcnt, nd);
      n_checks++;
      if (quotient !== 8'hFF || remainder !== 4'd0 || div_by_zero !== 1'b1) begin
         n_fail++;
         $display("FAIL div_zero_result: got q=%0h r=%0d dbz=%0b, want q=ff r=0 dbz=1",
                  quotient, remainder, div_by_zero);
      end
      n_checks++;
      if (lat !== 1 || bcnt !== 0 || nd !== 1) begin
         n_fail++;
         $display("FAIL div_zero_timing: got lat=%0d busy=%0d dones=%0d, want 1/0/1", lat, bcnt, nd);
      end
      run_div(8'd60, 4'd6, lat, bcnt, nd);
      n_checks++;
      if (quotient !== 8'd10 || remainder !== 4'd0 || div_by_zero !== 1'b0 || lat !== 9) begin
         n_fail++;
         $display("FAIL div_zero_recover: got q=%0d r=%0d dbz=%0b lat=%0d, want q=10 r=0 dbz=0 lat=9",
                  quotient, remainder, div_by_zero, lat);
      end
   endtask

   task automatic test_busy_protect();
      int nd = 0;
      int lat = -1;
      @(negedge clk);
      dividend = 8'd100; divisor = 4'd10; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 24; k++) begin
         if (k > 0) @(negedge clk);
         if (k == 2) begin start = 1'b1; dividend = 8'd50; divisor = 4'd5; end
         if (k == 3) start = 1'b0;
         if (k == 5) begin dividend = 8'd77; divisor = 4'd3; end
         if (done) begin
            nd++;
            if (lat < 0) lat = k + 1;
         end
      end
      n_checks++;
      if (nd !== 1 || lat !== 9 || quotient !== 8'd10 || remainder !== 4'd0) begin
         n_fail++;
         $display("FAIL busy_protect: got dones=%0d lat=%0d q=%0d r=%0d, want 1/9/10/0",
                  nd, lat, quotient, remainder);
      end
   endtask

   task automatic test_reset_midop();
      int nd = 0;
      int lat, bcnt, nd2;
      @(negedge clk);
      dividend = 8'd225; divisor = 4'd15; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      if (done) nd++;
      for (int k = 1; k < 4; k++) begin
         @(negedge clk);
         if (done) nd++;
      end
      rst = 1'b1;
      #1;
      n_checks++;
      if ({busy, done, quotient, remainder, div_by_zero} !== 15'd0) begin
         n_fail++;
         $display("FAIL reset_midop_outputs: got busy=%0b done=%0b q=%0d r=%0d dbz=%0b, want all 0",
                  busy, done, quotient, remainder, div_by_zero);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 14; k++) begin
         @(negedge clk);
         if (done || busy) nd++;
      end
      n_checks++;
      if (nd !== 0) begin
         n_fail++;
         $display("FAIL reset_midop_abort: got %0d done/busy cycles, want 0", nd);
      end
      run_div(8'd108, 4'd9, lat, bcnt, nd2);
      n_checks++;
      if (quotient !== 8'd12 || remainder !== 4'd0 || lat !== 9 || nd2 !== 1) begin
         n_fail++;
         $display("FAIL reset_midop_fresh: got q=%0d r=%0d lat=%0d dones=%0d, want 12/0/9/1",
                  quotient, remainder, lat, nd2);
      end
   endtask

   initial begin
      test_reset();
      test_round_trip();
      test_edges();
      test_div_zero();
      test_busy_protect();
      test_reset_midop();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
